if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline.
- Owns the PC register and the IF/ID pipeline register, and drives instruction-memory addressing.
- Consumes the branch-resolution outputs (branch-taken select and 32-bit branch target) from the EX-stage branch logic, plus the stall from the hazard unit.
- Produces the fetched instruction, its PC and a valid bit for the decode stage.

Parameters:
- PC_W, 9, width of the program counter and of the instruction-memory byte address.
- NOP_INSTR, 32'h00000013, encoding inserted into IF/ID on bubbles and flushes (addi x0,x0,0).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit stall: hold PC and IF/ID.
- PcSel  input  1  branch/jump taken in EX; redirect fetch.
- BrPC  input  32  redirect target byte address; valid when PcSel=1.
- imem_ready  input  1  instruction memory has valid read data for imem_addr this cycle.
- imem_rdata  input  32  instruction word at imem_addr (combinational read).
- imem_addr  output  PC_W  byte address to instruction memory; equals pc_q.
- ifid_pc  output  PC_W  PC of the instruction held in IF/ID.
- ifid_instr  output  32  instruction held in IF/ID.
- ifid_valid  output  1  IF/ID holds a real instruction.
- flush_out  output  1  combinational copy of PcSel; tells ID/EX to squash.
- redirect_cnt  output  16  taken-redirect count (see Optional Feature).
- bubble_cnt  output  16  IMEM-wait bubble count (see Optional Feature).

Behaviour:
- Reset values: pc_q=0, ifid_pc=0, ifid_instr=NOP_INSTR, ifid_valid=0, counters=0. flush_out follows PcSel even during reset.
- Update priority each rising edge: reset > redirect (PcSel=1) > stall > imem wait (imem_ready=0) > normal fetch.
- Redirect (PcSel=1):
  - pc_q <= BrPC[PC_W-1:0] with bits [1:0] forced to 0.
  - IF/ID flushed: ifid_valid<=0, ifid_instr<=NOP_INSTR, ifid_pc<=0.
  - Applies regardless of stall or imem_ready; redirect overrides stall.
  - BrPC bits above PC_W are ignored.
- Stall (PcSel=0, stall=1): pc_q and all IF/ID outputs hold. imem_ready is ignored.
- IMEM wait (PcSel=0, stall=0, imem_ready=0):
  - pc_q holds.
  - Bubble inserted: ifid_valid<=0, ifid_instr<=NOP_INSTR, ifid_pc<=pc_q.
- Normal fetch (PcSel=0, stall=0, imem_ready=1):
  - ifid_pc<=pc_q, ifid_instr<=imem_rdata, ifid_valid<=1.
  - pc_q <= pc_q+4, modulo 2^PC_W; wrap from 2^PC_W-4 to 0 silently.
- Latency: an instruction at address A appears on ifid_* one cycle after the edge where pc_q==A and the fetch completes.
- imem_addr = pc_q combinationally; no other combinational path from inputs to ifid_*.
- Reset asserted mid-stream: next edge returns to reset values; any simultaneous PcSel or stall is ignored.
- Deassertion of reset: first fetch at address 0 on the following edge, if imem_ready=1.

Optional Feature:
- Macro: IF_STAGE_PERF_CNT_EN.
- Defined:
  - redirect_cnt increments on every edge with reset=0 and PcSel=1.
  - bubble_cnt increments on every edge taking the IMEM-wait branch.
  - Both are 16-bit, saturate at 16'hFFFF and clear on reset.
- Not defined: redirect_cnt and bubble_cnt are tied to 16'h0000 and no counter flops are synthesized. Ports remain present.

Test Plan:
- Reset then 4 cycles of imem_ready=1, rdata=0xA0+cycle -> ifid_pc 0,4,8,12 with ifid_valid=1; pc_q=16.
- stall=1 for 3 cycles after pc_q=8 -> pc_q and ifid_pc/instr/valid frozen 3 cycles; fetch resumes at 8.
- PcSel=1, BrPC=0x0000_0123 with stall=1 -> pc_q=0x120, ifid_valid=0, ifid_instr=0x00000013, flush_out=1 that cycle; next fetch at 0x120.
- imem_ready=0 for 2 cycles at pc_q=0x40 -> two bubbles (valid=0, NOP); then fetch 0x40 and pc_q=0x44. With IF_STAGE_PERF_CNT_EN, bubble_cnt=2.
- pc_q=0x1FC, PC_W=9, normal fetch -> ifid_pc=0x1FC, pc_q wraps to 0x000.
- Reset asserted while PcSel=1, BrPC=0x80 -> pc_q=0, ifid_valid=0; with IF_STAGE_PERF_CNT_EN, counters cleared and redirect_cnt not incremented.

Source files
------------

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the 5-stage RISC-V pipeline.
//
// Owns the PC register and the IF/ID pipeline register. Drives the
// instruction-memory address straight from the PC register. Takes branch
// redirects from EX and stalls from the hazard unit.
//
// Update priority on each rising edge:
//   reset > redirect (PcSel) > stall > imem wait (!imem_ready) > fetch
//
// Ports:
//   clk           pipeline clock, rising-edge active
//   reset         synchronous, active-high reset
//   stall         hold PC and IF/ID
//   PcSel         redirect fetch to BrPC (taken branch/jump in EX)
//   BrPC[31:0]    redirect target byte address (bits above PC_W ignored)
//   imem_ready    instruction memory data valid for imem_addr this cycle
//   imem_rdata    instruction word at imem_addr
//   imem_addr     byte address to instruction memory (= PC register)
//   ifid_pc       PC of the instruction held in IF/ID
//   ifid_instr    instruction held in IF/ID (NOP_INSTR on bubbles/flushes)
//   ifid_valid    IF/ID holds a real instruction
//   flush_out     combinational copy of PcSel, squashes ID/EX
//   redirect_cnt  saturating count of taken redirects
//   bubble_cnt    saturating count of imem-wait bubbles
//
// Build option:
//   IF_STAGE_PERF_CNT_EN  when defined, redirect_cnt/bubble_cnt are live
//                         16-bit saturating counters cleared on reset.
//                         When undefined, both ports are tied to zero and
//                         no counter flops exist.
// ----------------------------------------------------------------------------
module if_stage #(
    parameter int          PC_W      = 9,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            PcSel,
    input  logic [31:0]     BrPC,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [PC_W-1:0] imem_addr,
    output logic [PC_W-1:0] ifid_pc,
    output logic [31:0]     ifid_instr,
    output logic            ifid_valid,
    output logic            flush_out,
    output logic [15:0]     redirect_cnt,
    output logic [15:0]     bubble_cnt
);

    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] ifid_pc_r;
    logic [31:0]     ifid_instr_r;
    logic            ifid_valid_r;

    logic [PC_W-1:0] pc_next_s;
    logic [PC_W-1:0] ifid_pc_next_s;
    logic [31:0]     ifid_instr_next_s;
    logic            ifid_valid_next_s;

    // Only BrPC[PC_W-1:2] forms the target; the rest is deliberately dropped.
    logic            unused_brpc_s;
    assign unused_brpc_s = ^{BrPC[31:PC_W], BrPC[1:0]};

    // Next-state selection for PC and IF/ID by redirect > stall > wait > fetch.
    always_comb begin
        pc_next_s         = pc_r;
        ifid_pc_next_s    = ifid_pc_r;
        ifid_instr_next_s = ifid_instr_r;
        ifid_valid_next_s = ifid_valid_r;
        if (PcSel) begin
            // Word-align the target; the flushed slot carries no PC.
            pc_next_s         = {BrPC[PC_W-1:2], 2'b00};
            ifid_pc_next_s    = {PC_W{1'b0}};
            ifid_instr_next_s = NOP_INSTR;
            ifid_valid_next_s = 1'b0;
        end else if (stall) begin
            pc_next_s         = pc_r;
            ifid_pc_next_s    = ifid_pc_r;
            ifid_instr_next_s = ifid_instr_r;
            ifid_valid_next_s = ifid_valid_r;
        end else if (!imem_ready) begin
            // Bubble tagged with the PC being waited on; PC holds for retry.
            pc_next_s         = pc_r;
            ifid_pc_next_s    = pc_r;
            ifid_instr_next_s = NOP_INSTR;
            ifid_valid_next_s = 1'b0;
        end else begin
            // Wraps modulo 2^PC_W by plain truncation.
            pc_next_s         = pc_r + PC_W'(4);
            ifid_pc_next_s    = pc_r;
            ifid_instr_next_s = imem_rdata;
            ifid_valid_next_s = 1'b1;
        end
    end

    // PC and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r         <= {PC_W{1'b0}};
            ifid_pc_r    <= {PC_W{1'b0}};
            ifid_instr_r <= NOP_INSTR;
            ifid_valid_r <= 1'b0;
        end else begin
            pc_r         <= pc_next_s;
            ifid_pc_r    <= ifid_pc_next_s;
            ifid_instr_r <= ifid_instr_next_s;
            ifid_valid_r <= ifid_valid_next_s;
        end
    end

    assign imem_addr  = pc_r;
    assign ifid_pc    = ifid_pc_r;
    assign ifid_instr = ifid_instr_r;
    assign ifid_valid = ifid_valid_r;
    assign flush_out  = PcSel;

`ifdef IF_STAGE_PERF_CNT_EN
    logic [15:0] redirect_cnt_r;
    logic [15:0] bubble_cnt_r;
    logic        redirect_ev_s;
    logic        bubble_ev_s;

    assign redirect_ev_s = PcSel;
    assign bubble_ev_s   = ~PcSel & ~stall & ~imem_ready;

    // Saturating event counters; reset wins over any same-cycle event.
    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_cnt_r <= 16'h0000;
            bubble_cnt_r   <= 16'h0000;
        end else begin
            if (redirect_ev_s && (redirect_cnt_r != 16'hFFFF)) begin
                redirect_cnt_r <= redirect_cnt_r + 16'h0001;
            end else begin
                redirect_cnt_r <= redirect_cnt_r;
            end
            if (bubble_ev_s && (bubble_cnt_r != 16'hFFFF)) begin
                bubble_cnt_r <= bubble_cnt_r + 16'h0001;
            end else begin
                bubble_cnt_r <= bubble_cnt_r;
            end
        end
    end

    assign redirect_cnt = redirect_cnt_r;
    assign bubble_cnt   = bubble_cnt_r;
`else
    assign redirect_cnt = 16'h0000;
    assign bubble_cnt   = 16'h0000;
`endif

endmodule
